// File: rtl/matseq_pkg.sv
// rtl/matseq_pkg.sv - shared types and helpers for the matrix multiply sequencer
package matseq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam int DEFAULT_TIMEOUT = 64;

  // Index width for a DIM-sized axis, never narrower than one bit.
  function automatic int idx_w(input int dim);
    return (dim <= 2) ? 1 : $clog2(dim);
  endfunction

endpackage

// File: rtl/matseq_if.sv
// rtl/matseq_if.sv - sequencer to element-engine and C-store handshake bundle
interface matseq_if #(
  parameter int IDX_W  = 2,
  parameter int ADDR_W = 8
);
  logic              elem_start;
  logic              elem_done;
  logic [IDX_W-1:0]  row;
  logic [IDX_W-1:0]  col;
  logic [ADDR_W-1:0] c_addr;
  logic              c_write;

  modport master (output elem_start, row, col, c_addr, c_write, input elem_done);
  modport slave  (input elem_start, row, col, c_addr, c_write, output elem_done);
endinterface

// File: rtl/matseq_index_counter.sv
// rtl/matseq_index_counter.sv - row-major 2-D (row, col) walker over a DIM x DIM grid
module matseq_index_counter
  import matseq_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int IDX_W = idx_w(DIM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(DIM - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == MAX_IDX) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == MAX_IDX) && (col == MAX_IDX);
endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - walks every C element, starts the engine, writes results
// Optional MATSEQ_TIMEOUT_EN: bound each WAIT to TIMEOUT cycles and flag error.
module matmul_sequencer
  import matseq_pkg::*;
#(
  parameter int DIM     = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      go,
  input  logic      abort,
  matseq_if.master  eng,
  output logic      busy,
  output logic      done,
  output logic      error
);
  localparam int IDX_W = idx_w(DIM);

  state_t           state, next_state;
  logic [IDX_W-1:0] row_q, col_q;
  logic             last, clear_idx, advance_idx, timed_out;

  matseq_index_counter #(.DIM(DIM), .IDX_W(IDX_W)) u_idx (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear_idx),
    .advance (advance_idx),
    .row     (row_q),
    .col     (col_q),
    .last    (last)
  );

  assign eng.row    = row_q;
  assign eng.col    = col_q;
  assign eng.c_addr = ADDR_W'(row_q) * ADDR_W'(DIM) + ADDR_W'(col_q);

`ifdef MATSEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             error_q;

  always_ff @(posedge clock) begin
    if (reset || state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)      wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th consecutive WAIT cycle without a response.
  assign timed_out = (state == WAIT) && !eng.elem_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset)                     error_q <= 1'b0;
    else if (state == IDLE && go)  error_q <= 1'b0;
    else if (timed_out && !abort)  error_q <= 1'b1;
  end
  assign error = error_q;
`else
  assign timed_out = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (go) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT: begin
        if (eng.elem_done)  next_state = WRITE;
        else if (timed_out) next_state = FINISH;
      end
      WRITE:   next_state = last ? FINISH : ISSUE;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // abort overrides every transition out of a busy state, elem_done included
    if (abort && state != IDLE) next_state = IDLE;
  end

  always_comb begin
    eng.elem_start = 1'b0;
    eng.c_write    = 1'b0;
    done           = 1'b0;
    busy           = (state != IDLE);
    clear_idx      = (state == IDLE) && go;
    advance_idx    = 1'b0;
    unique case (state)
      ISSUE:  eng.elem_start = !abort;
      WRITE: begin
        eng.c_write = !abort;
        advance_idx = !abort && !last;
      end
      FINISH: done = !abort;
      default: ;
    endcase
  end
endmodule
